id_ex_stage: RTL and testbench

- ID/EX pipeline boundary. Registers decoded operands and control into the execute stage.
- Computes registered forwardA/forwardB for the execute-stage ALU.
- Detects load-use hazards and issues a stall with a bubble.
- Applies branch/trap flush.
- Sits between decode/regfile and the ALU; outputs drive ALU inputs directly.

---
 rtl/riscv_pipe_pkg.sv | 42 ++++
 rtl/id_ex_stage_hazard_compare.sv | 35 +++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants: control-bundle layout, forward selects, ALU/WB codes
package riscv_pipe_pkg;

  localparam int CTRL_W = 12;

  // Control bundle layout: {csr_reg_en, memwrite, memread, regwen, WBSel[1:0], operation[3:0], BSel, ASel}
  localparam int CTRL_ASEL      = 0;
  localparam int CTRL_BSEL      = 1;
  localparam int CTRL_OP_LSB    = 2;
  localparam int CTRL_OP_MSB    = 5;
  localparam int CTRL_WBSEL_LSB = 6;
  localparam int CTRL_WBSEL_MSB = 7;
  localparam int CTRL_REGWEN    = 8;
  localparam int CTRL_MEMREAD   = 9;
  localparam int CTRL_MEMWRITE  = 10;
  localparam int CTRL_CSR_EN    = 11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_DMEM = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/id_ex_stage_hazard_compare.sv
// rtl/id_ex_stage_hazard_compare.sv - per-operand forward select and load-use detection
module hazard_compare
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwen,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwen,
  output logic [1:0] fwd,
  output logic       load_use
);

  logic ex_match;
  logic mem_match;

  // x0 is hardwired, so a zero rd never matches
  assign ex_match  = ex_valid & rs_used & (ex_rd != 5'd0) & (ex_rd == rs);
  assign mem_match = mem_regwen & rs_used & (mem_rd != 5'd0) & (mem_rd == rs);

  assign load_use = ex_match & ex_memread;

  always_comb begin
    fwd = FWD_NONE;
    if (ex_match && ex_regwen) begin
      fwd = FWD_MEM;
    end else if (mem_match) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and flush
// Optional HAZARD_STATS_EN adds saturating stall_count/flush_count outputs.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [XLEN-1:0]   ID_rdata1,
  input  logic [XLEN-1:0]   ID_rdata2,
  input  logic [XLEN-1:0]   ID_imm,
  input  logic [4:0]        ID_rs1,
  input  logic [4:0]        ID_rs2,
  input  logic [1:0]        ID_rs_used,
  input  logic [4:0]        ID_rd,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic [4:0]        MEM_rd,
  input  logic              MEM_regwen,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count,
`endif
  output logic              EX_valid,
  output logic [XLEN-1:0]   EX_PC,
  output logic [XLEN-1:0]   EX_rdata1,
  output logic [XLEN-1:0]   EX_rdata2,
  output logic [XLEN-1:0]   EX_imm,
  output logic [4:0]        EX_rd,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              stall
);
  import riscv_pipe_pkg::*;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lu_a;
  logic       lu_b;

  hazard_compare u_cmp_rs1 (
    .rs         (ID_rs1),
    .rs_used    (ID_rs_used[0]),
    .ex_valid   (EX_valid),
    .ex_rd      (EX_rd),
    .ex_regwen  (EX_ctrl[CTRL_REGWEN]),
    .ex_memread (EX_ctrl[CTRL_MEMREAD]),
    .mem_rd     (MEM_rd),
    .mem_regwen (MEM_regwen),
    .fwd        (fwd_a),
    .load_use   (lu_a)
  );

  hazard_compare u_cmp_rs2 (
    .rs         (ID_rs2),
    .rs_used    (ID_rs_used[1]),
    .ex_valid   (EX_valid),
    .ex_rd      (EX_rd),
    .ex_regwen  (EX_ctrl[CTRL_REGWEN]),
    .ex_memread (EX_ctrl[CTRL_MEMREAD]),
    .mem_rd     (MEM_rd),
    .mem_regwen (MEM_regwen),
    .fwd        (fwd_b),
    .load_use   (lu_b)
  );

  assign stall = lu_a | lu_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_valid  <= 1'b0;
      EX_PC     <= '0;
      EX_rdata1 <= '0;
      EX_rdata2 <= '0;
      EX_imm    <= '0;
      EX_rd     <= 5'd0;
      EX_ctrl   <= '0;
      forwardA  <= FWD_NONE;
      forwardB  <= FWD_NONE;
    end else if (!hold) begin
      if (flush || stall) begin
        EX_valid  <= 1'b0;
        EX_PC     <= '0;
        EX_rdata1 <= '0;
        EX_rdata2 <= '0;
        EX_imm    <= '0;
        EX_rd     <= 5'd0;
        EX_ctrl   <= '0;
        forwardA  <= FWD_NONE;
        forwardB  <= FWD_NONE;
      end else begin
        EX_valid  <= ID_valid;
        EX_PC     <= ID_PC;
        EX_rdata1 <= ID_rdata1;
        EX_rdata2 <= ID_rdata2;
        EX_imm    <= ID_imm;
        EX_rd     <= ID_rd;
        // An empty decode slot must not carry write/memory side effects into EX
        EX_ctrl   <= ID_valid ? ID_ctrl : '0;
        forwardA  <= ID_valid ? fwd_a : FWD_NONE;
        forwardB  <= ID_valid ? fwd_b : FWD_NONE;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!hold) begin
      if (flush) begin
        if (flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
      end else if (stall) begin
        if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_valid;
  logic [31:0] ID_PC, ID_rdata1, ID_rdata2, ID_imm;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic [1:0]  ID_rs_used;
  logic [11:0] ID_ctrl;
  logic        flush, hold;
  logic [4:0]  MEM_rd;
  logic        MEM_regwen;
  logic        EX_valid;
  logic [31:0] EX_PC, EX_rdata1, EX_rdata2, EX_imm;
  logic [4:0]  EX_rd;
  logic [11:0] EX_ctrl;
  logic [1:0]  forwardA, forwardB;
  logic        stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CTRL_W(12)) dut (
    .clk(clk), .rst(rst),
    .ID_valid(ID_valid), .ID_PC(ID_PC), .ID_rdata1(ID_rdata1), .ID_rdata2(ID_rdata2),
    .ID_imm(ID_imm), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs_used(ID_rs_used),
    .ID_rd(ID_rd), .ID_ctrl(ID_ctrl), .flush(flush), .hold(hold),
    .MEM_rd(MEM_rd), .MEM_regwen(MEM_regwen),
`ifdef HAZARD_STATS_EN
    .stall_count(stall_count), .flush_count(flush_count),
`endif
    .EX_valid(EX_valid), .EX_PC(EX_PC), .EX_rdata1(EX_rdata1), .EX_rdata2(EX_rdata2),
    .EX_imm(EX_imm), .EX_rd(EX_rd), .EX_ctrl(EX_ctrl),
    .forwardA(forwardA), .forwardB(forwardB), .stall(stall)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic [31:0] pc;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_regwen;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [11:0] e_ctrl;
    logic [31:0] e_pc;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  localparam logic [11:0] C_ADD  = 12'h140;
  localparam logic [11:0] C_SUB  = 12'h144;
  localparam logic [11:0] C_OR   = 12'h14C;
  localparam logic [11:0] C_ADDI = 12'h142;
  localparam logic [11:0] C_LW   = 12'h302;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] d1(input logic [31:0] pc);
    return (pc == 32'd0) ? 32'd0 : (pc ^ 32'hA5A5_0000);
  endfunction
  function automatic logic [31:0] d2(input logic [31:0] pc);
    return (pc == 32'd0) ? 32'd0 : (pc ^ 32'h0000_5A5A);
  endfunction
  function automatic logic [31:0] dimm(input logic [31:0] pc);
    return (pc == 32'd0) ? 32'd0 : (pc + 32'd4);
  endfunction

  task automatic drive_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [1:0] u, input logic [4:0] rd, input logic [11:0] c,
                          input logic [31:0] pc);
    ID_valid = v; ID_rs1 = r1; ID_rs2 = r2; ID_rs_used = u; ID_rd = rd; ID_ctrl = c;
    ID_PC = pc; ID_rdata1 = d1(pc); ID_rdata2 = d2(pc); ID_imm = dimm(pc);
  endtask

  initial begin
    //            v  rs1 rs2 used rd  ctrl    pc        fl memrd mwe  stall ev erd ectrl   epc       fa     fb
    vecs[0]  = '{1, 1,  2,  3,   5,  C_ADD,  32'h100, 0, 0,    0,   0,    1, 5,  C_ADD,  32'h100, 2'b00, 2'b00};
    vecs[1]  = '{1, 5,  7,  3,   6,  C_SUB,  32'h104, 0, 0,    0,   0,    1, 6,  C_SUB,  32'h104, 2'b10, 2'b00};
    vecs[2]  = '{0, 0,  0,  0,   0,  12'h0,  32'h108, 0, 5,    1,   0,    0, 0,  12'h0,  32'h108, 2'b00, 2'b00};
    vecs[3]  = '{1, 1,  1,  3,   5,  C_ADD,  32'h10C, 0, 6,    1,   0,    1, 5,  C_ADD,  32'h10C, 2'b00, 2'b00};
    vecs[4]  = '{0, 0,  0,  0,   0,  12'h0,  32'h110, 0, 0,    0,   0,    0, 0,  12'h0,  32'h110, 2'b00, 2'b00};
    vecs[5]  = '{1, 5,  5,  3,   8,  C_OR,   32'h114, 0, 5,    1,   0,    1, 8,  C_OR,   32'h114, 2'b01, 2'b01};
    vecs[6]  = '{1, 2,  0,  1,   3,  C_LW,   32'h118, 0, 0,    0,   0,    1, 3,  C_LW,   32'h118, 2'b00, 2'b00};
    vecs[7]  = '{1, 3,  1,  3,   4,  C_ADD,  32'h11C, 0, 8,    1,   1,    0, 0,  12'h0,  32'h0,   2'b00, 2'b00};
    vecs[8]  = '{1, 3,  1,  3,   4,  C_ADD,  32'h11C, 0, 3,    1,   0,    1, 4,  C_ADD,  32'h11C, 2'b01, 2'b00};
    vecs[9]  = '{1, 1,  2,  3,   0,  C_ADD,  32'h120, 0, 0,    0,   0,    1, 0,  C_ADD,  32'h120, 2'b00, 2'b00};
    vecs[10] = '{1, 0,  4,  1,   9,  C_ADDI, 32'h124, 0, 4,    1,   0,    1, 9,  C_ADDI, 32'h124, 2'b00, 2'b00};
    vecs[11] = '{1, 9,  0,  1,   3,  C_LW,   32'h128, 0, 0,    1,   0,    1, 3,  C_LW,   32'h128, 2'b10, 2'b00};
    vecs[12] = '{1, 3,  3,  3,   4,  C_ADD,  32'h12C, 1, 9,    1,   1,    0, 0,  12'h0,  32'h0,   2'b00, 2'b00};
    vecs[13] = '{1, 9,  9,  3,   10, C_ADD,  32'h130, 0, 3,    1,   0,    1, 10, C_ADD,  32'h130, 2'b00, 2'b00};

    rst = 1'b1; flush = 1'b0; hold = 1'b0; MEM_rd = 5'd0; MEM_regwen = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 12'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset EX_valid", {31'd0, EX_valid}, 32'd0);
    chk("reset EX_ctrl", {20'd0, EX_ctrl}, 32'd0);
    chk("reset fwd", {28'd0, forwardA, forwardB}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset EX_PC", EX_PC, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_id(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].used, vecs[i].rd,
               vecs[i].ctrl, vecs[i].pc);
      flush = vecs[i].flush; MEM_rd = vecs[i].mem_rd; MEM_regwen = vecs[i].mem_regwen;
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d EX_valid", i), {31'd0, EX_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d EX_rd", i), {27'd0, EX_rd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d EX_ctrl", i), {20'd0, EX_ctrl}, {20'd0, vecs[i].e_ctrl});
      chk($sformatf("v%0d EX_PC", i), EX_PC, vecs[i].e_pc);
      chk($sformatf("v%0d EX_rdata1", i), EX_rdata1, d1(vecs[i].e_pc));
      chk($sformatf("v%0d EX_rdata2", i), EX_rdata2, d2(vecs[i].e_pc));
      chk($sformatf("v%0d EX_imm", i), EX_imm, dimm(vecs[i].e_pc));
      chk($sformatf("v%0d forwardA", i), {30'd0, forwardA}, {30'd0, vecs[i].e_fa});
      chk($sformatf("v%0d forwardB", i), {30'd0, forwardB}, {30'd0, vecs[i].e_fb});
    end

`ifdef HAZARD_STATS_EN
    chk("stall_count", stall_count, 32'd1);
    chk("flush_count", flush_count, 32'd1);
`endif

    // Freeze for three edges with a fresh dependent instruction waiting in ID
    @(negedge clk);
    drive_id(1'b1, 5'd10, 5'd10, 2'b11, 5'd11, C_SUB, 32'h200);
    flush = 1'b0; hold = 1'b1; MEM_rd = 5'd0; MEM_regwen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d EX_valid", k), {31'd0, EX_valid}, 32'd1);
      chk($sformatf("hold%0d EX_PC", k), EX_PC, 32'h130);
      chk($sformatf("hold%0d EX_rd", k), {27'd0, EX_rd}, 32'd10);
      chk($sformatf("hold%0d EX_ctrl", k), {20'd0, EX_ctrl}, {20'd0, C_ADD});
      chk($sformatf("hold%0d fwd", k), {28'd0, forwardA, forwardB}, 32'd0);
    end

    // Asynchronous reset between edges while still held
    #2;
    rst = 1'b1;
    #1;
    chk("async rst EX_valid", {31'd0, EX_valid}, 32'd0);
    chk("async rst EX_PC", EX_PC, 32'd0);
    chk("async rst EX_rdata1", EX_rdata1, 32'd0);
    chk("async rst EX_rd", {27'd0, EX_rd}, 32'd0);
    chk("async rst EX_ctrl", {20'd0, EX_ctrl}, 32'd0);
    chk("async rst stall", {31'd0, stall}, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("async rst stall_count", stall_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
